// File: rtl/ludm_pkg.sv
// Shared types and fixed-point helpers for the LU decomposition engine.
package ludm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PIVOT,
        DIV_START,
        DIV_WAIT,
        WR_L,
        UPDATE,
        NEXT_ROW,
        DONE,
        ERR
    } state_e;

    // Full-width product, arithmetic shift; caller keeps the low bits.
    function automatic logic signed [63:0] fx_mul(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 frac
    );
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p >>> frac;
    endfunction

    function automatic logic [31:0] fx_one(input int frac);
        return 32'd1 << frac;
    endfunction

endpackage

// File: rtl/ludm_sdiv.sv
// Sequential signed restoring divider, one quotient bit per cycle.
// Works on magnitudes; the sign is applied to the final quotient.
module ludm_sdiv #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DW+FRAC-1:0] num,
    input  logic [DW-1:0]      den,
    output logic [DW-1:0]      quo,
    output logic               done
);

    localparam int NW = DW + FRAC;
    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0] q_q, q_d, qn;
    logic [DW-1:0] r_q, r_d, d_q, d_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [DW:0]   rs;
    logic          ge;

    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        d_d    = d_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        quo_d  = quo_q;
        rs     = {r_q, q_q[NW-1]};
        ge     = rs >= {1'b0, d_q};
        qn     = {q_q[NW-2:0], ge};
        if (start) begin
            q_d   = num[NW-1] ? NW'(-num) : num;
            d_d   = den[DW-1] ? DW'(-den) : den;
            r_d   = '0;
            neg_d = num[NW-1] ^ den[DW-1];
            cnt_d = CW'(NW);
            run_d = 1'b1;
        end else if (run_q) begin
            q_d   = qn;
            r_d   = ge ? DW'(rs - {1'b0, d_q}) : rs[DW-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
                quo_d  = DW'(neg_q ? -qn : qn);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            quo_q  <= '0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            d_q    <= d_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
            quo_q  <= quo_d;
        end
    end

    assign quo  = quo_q;
    assign done = done_q;

endmodule

// File: rtl/ludm_param.sv
// In-place Doolittle LU factorisation of an NxN fixed-point matrix.
// L and U share one array; readback splits it by row/col position.
module ludm_param
    import ludm_pkg::*;
#(
    parameter int N    = 3,
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int AW   = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] L,
    output logic [DW-1:0] U,
    output logic          busy,
    output logic          finish,
    output logic          err
);

    localparam int NN = N * N;
    localparam int CW = $clog2(N + 1);
    localparam logic [DW-1:0] ONE = DW'(fx_one(FRAC));

    state_e        state_q, state_d;
    logic [CW-1:0] k_q, k_d, i_q, i_d, j_q, j_d;
    logic          busy_q, busy_d, fin_q, fin_d, err_q, err_d;
    logic [DW-1:0] l_q, l_d, u_q, u_d;
    logic [DW-1:0] a_q [NN];
    logic [DW-1:0] a_d [NN];

    logic signed [DW-1:0] l_ik, a_kj;
    logic [DW-1:0] a_kk, prod, div_quo;
    logic          div_start, div_done;
    int            rd_row, rd_col;

    function automatic logic [AW-1:0] fidx(
        input logic [CW-1:0] r,
        input logic [CW-1:0] c
    );
        return AW'(int'(r) * N + int'(c));
    endfunction

    assign a_kk      = a_q[fidx(k_q, k_q)];
    assign l_ik      = a_q[fidx(i_q, k_q)];
    assign a_kj      = a_q[fidx(k_q, j_q)];
    assign prod      = DW'(fx_mul(32'(l_ik), 32'(a_kj), FRAC));
    assign div_start = (state_q == DIV_START);

    ludm_sdiv #(.DW(DW), .FRAC(FRAC)) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   ({l_ik, {FRAC{1'b0}}}),
        .den   (a_kk),
        .quo   (div_quo),
        .done  (div_done)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        busy_d  = busy_q;
        fin_d   = fin_q;
        err_d   = err_q;
        a_d     = a_q;
        if (wr && !busy_q && int'(wr_addr) < NN)
            a_d[wr_addr] = wr_data;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = PIVOT;
                    k_d     = '0;
                    i_d     = CW'(1);
                    busy_d  = 1'b1;
                    fin_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            PIVOT: begin
                if (a_kk == '0) begin
                    state_d = ERR;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = DIV_START;
                end
            end
            DIV_START: state_d = DIV_WAIT;
            DIV_WAIT: if (div_done) state_d = WR_L;
            WR_L: begin
                a_d[fidx(i_q, k_q)] = div_quo;
                j_d     = k_q + 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                a_d[fidx(i_q, j_q)] = a_q[fidx(i_q, j_q)] - prod;
                if (j_q == CW'(N - 1))
                    state_d = NEXT_ROW;
                else
                    j_d = j_q + 1'b1;
            end
            NEXT_ROW: begin
                if (i_q + 1'b1 < CW'(N)) begin
                    i_d     = i_q + 1'b1;
                    state_d = DIV_START;
                end else begin
                    k_d = k_q + 1'b1;
                    i_d = k_q + CW'(2);
                    if (k_q + 1'b1 < CW'(N - 1)) begin
                        state_d = PIVOT;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        fin_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        l_d    = '0;
        u_d    = '0;
        rd_row = int'(rd_addr) / N;
        rd_col = int'(rd_addr) % N;
        if (int'(rd_addr) < NN) begin
            if (rd_row > rd_col)
                l_d = a_q[rd_addr];
            else if (rd_row == rd_col)
                l_d = ONE;
            if (rd_row <= rd_col)
                u_d = a_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            l_q     <= '0;
            u_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            l_q     <= l_d;
            u_q     <= u_d;
        end
    end

    // Matrix storage survives reset; only writes are held off.
    always_ff @(posedge clk) begin
        if (reset)
            a_q <= a_d;
    end

    assign L      = l_q;
    assign U      = u_q;
    assign busy   = busy_q;
    assign finish = fin_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ludm_param.sv
// Bench for ludm_param: directed cases plus random matrices
// checked against a plain-arithmetic Doolittle reference.
module tb_ludm_param;

    logic clk = 1'b0;
    logic reset;

    logic        wr2, st2, busy2, fin2, err2;
    logic [1:0]  wa2, ra2;
    logic [15:0] wd2, lo2, up2;

    logic        wr3, st3, busy3, fin3, err3;
    logic [3:0]  wa3, ra3;
    logic [15:0] wd3, lo3, up3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ludm_param #(.N(2), .DW(16), .FRAC(8)) dut2 (
        .clk(clk), .reset(reset), .wr(wr2), .wr_addr(wa2),
        .wr_data(wd2), .start(st2), .rd_addr(ra2), .L(lo2),
        .U(up2), .busy(busy2), .finish(fin2), .err(err2)
    );

    ludm_param #(.N(3), .DW(16), .FRAC(8)) dut3 (
        .clk(clk), .reset(reset), .wr(wr3), .wr_addr(wa3),
        .wr_data(wd3), .start(st3), .rd_addr(ra3), .L(lo3),
        .U(up3), .busy(busy3), .finish(fin3), .err(err3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint w16(input longint x);
        return longint'(shortint'(x));
    endfunction

    // Cycles busy stays high: per pivot 1, per row div + update cost.
    function automatic int lat(input int n);
        int t = 0;
        for (int k = 0; k < n - 1; k++)
            t += 1 + (n - 1 - k) * (16 + 8 + 4 + (n - 1 - k));
        return t;
    endfunction

    task automatic model(input int n, input int m[9],
                         output int el[9], output int eu[9],
                         output bit e);
        longint a[9];
        e = 1'b0;
        for (int x = 0; x < 9; x++) a[x] = m[x];
        for (int k = 0; k < n - 1 && !e; k++) begin
            if (a[k*n+k] == 0) begin
                e = 1'b1;
            end else begin
                for (int i = k + 1; i < n; i++) begin
                    longint l;
                    l = w16((a[i*n+k] * 256) / a[k*n+k]);
                    a[i*n+k] = l;
                    for (int j = k + 1; j < n; j++)
                        a[i*n+j] = w16(a[i*n+j] - w16((l * a[k*n+j]) >>> 8));
                end
            end
        end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                el[r*n+c] = r > c ? int'(a[r*n+c]) : (r == c ? 256 : 0);
                eu[r*n+c] = r <= c ? int'(a[r*n+c]) : 0;
            end
    endtask

    task automatic load(input int sel, input int m[9]);
        for (int x = 0; x < sel * sel; x++) begin
            if (sel == 2) begin
                wr2 = 1'b1; wa2 = 2'(x); wd2 = 16'(m[x]);
            end else begin
                wr3 = 1'b1; wa3 = 4'(x); wd3 = 16'(m[x]);
            end
            tick;
        end
        wr2 = 1'b0;
        wr3 = 1'b0;
    endtask

    // inj >= 0: drive wr + start into the busy DUT at that cycle.
    task automatic run(input int sel, input int inj, output int cyc);
        if (sel == 2) st2 = 1'b1; else st3 = 1'b1;
        tick;
        st2 = 1'b0;
        st3 = 1'b0;
        cyc = 0;
        while (((sel == 2) ? busy2 : busy3) && cyc < 3000) begin
            if (cyc == inj) begin
                wr3 = 1'b1; wa3 = 4'd0; wd3 = 16'h7fff; st3 = 1'b1;
                wr2 = 1'b1; wa2 = 2'd0; wd2 = 16'h7fff; st2 = 1'b1;
            end
            tick;
            cyc++;
            wr2 = 1'b0; st2 = 1'b0;
            wr3 = 1'b0; st3 = 1'b0;
        end
    endtask

    task automatic rd(input int sel, input int addr,
                      output logic [15:0] l, output logic [15:0] u);
        if (sel == 2) ra2 = 2'(addr); else ra3 = 4'(addr);
        tick;
        l = (sel == 2) ? lo2 : lo3;
        u = (sel == 2) ? up2 : up3;
    endtask

    task automatic check_all(input int sel, input string tag,
                             input int el[9], input int eu[9]);
        logic [15:0] l, u;
        for (int x = 0; x < sel * sel; x++) begin
            rd(sel, x, l, u);
            chk($sformatf("%s_L%0d", tag, x), l, 16'(el[x]));
            chk($sformatf("%s_U%0d", tag, x), u, 16'(eu[x]));
        end
    endtask

    initial begin
        int m[9], el[9], eu[9];
        int cyc;
        bit me;
        logic [15:0] l, u;

        reset = 1'b1;
        {wr2, st2, wa2, ra2, wd2} = '0;
        {wr3, st3, wa3, ra3, wd3} = '0;
        #2 reset = 1'b0;
        repeat (3) tick;
        chk("rst_busy3", 16'(busy3), 16'd0);
        chk("rst_fin3", 16'(fin3), 16'd0);
        chk("rst_err3", 16'(err3), 16'd0);
        chk("rst_L3", lo3, 16'd0);
        chk("rst_U3", up3, 16'd0);
        chk("rst_busy2", 16'(busy2), 16'd0);
        chk("rst_fin2", 16'(fin2), 16'd0);
        reset = 1'b1;
        tick;

        // 2x2 directed: (4,3;6,3)
        m = '{1024, 768, 1536, 768, 0, 0, 0, 0, 0};
        load(2, m);
        run(2, -1, cyc);
        chk("n2_lat", 16'(cyc), 16'(lat(2)));
        chk("n2_fin", 16'(fin2), 16'd1);
        chk("n2_err", 16'(err2), 16'd0);
        check_all(2, "n2", '{256, 0, 384, 256, 0, 0, 0, 0, 0},
                  '{1024, 768, 0, -384, 0, 0, 0, 0, 0});

        // zero pivot: stops at the first PIVOT, no divide
        m = '{0, 256, 256, 0, 0, 0, 0, 0, 0};
        load(2, m);
        run(2, -1, cyc);
        chk("zp_lat", 16'(cyc), 16'd1);
        chk("zp_busy", 16'(busy2), 16'd0);
        chk("zp_fin", 16'(fin2), 16'd1);
        chk("zp_err", 16'(err2), 16'd1);

        // 3x3 directed
        m = '{512, 256, 256, 1024, 768, 768, 2048, 1792, 2304};
        load(3, m);
        run(3, -1, cyc);
        chk("n3_lat", 16'(cyc), 16'(lat(3)));
        chk("n3_fin", 16'(fin3), 16'd1);
        chk("n3_err", 16'(err3), 16'd0);
        check_all(3, "n3", '{256, 0, 0, 512, 256, 0, 1024, 768, 256},
                  '{512, 256, 256, 0, 256, 256, 0, 0, 512});

        // readback latency and out-of-range addresses
        rd(3, 0, l, u);
        chk("rb_diagL", l, 16'd256);
        chk("rb_u0", u, 16'd512);
        ra3 = 4'd5;
        #2;
        chk("rb_hold", up3, 16'd512);
        tick;
        chk("rb_next", up3, 16'd256);
        rd(3, 9, l, u);
        chk("rb_oorL", l, 16'd0);
        chk("rb_oorU", u, 16'd0);
        rd(3, 15, l, u);
        chk("rb_oor15", u, 16'd0);

        // wr and start while busy are ignored
        load(3, m);
        run(3, 4, cyc);
        chk("inj_lat", 16'(cyc), 16'(lat(3)));
        chk("inj_err", 16'(err3), 16'd0);
        check_all(3, "inj", '{256, 0, 0, 512, 256, 0, 1024, 768, 256},
                  '{512, 256, 256, 0, 256, 256, 0, 0, 512});

        // reset in DIV_WAIT aborts immediately
        load(3, m);
        rd(3, 4, l, u);
        st3 = 1'b1;
        tick;
        st3 = 1'b0;
        repeat (4) tick;
        chk("ab_busy_pre", 16'(busy3), 16'd1);
        #2 reset = 1'b0;
        #1;
        chk("ab_busy", 16'(busy3), 16'd0);
        chk("ab_fin", 16'(fin3), 16'd0);
        chk("ab_err", 16'(err3), 16'd0);
        chk("ab_L", lo3, 16'd0);
        chk("ab_U", up3, 16'd0);
        #2 reset = 1'b1;
        tick;
        load(3, m);
        run(3, -1, cyc);
        chk("ab_relat", 16'(cyc), 16'(lat(3)));
        check_all(3, "ab", '{256, 0, 0, 512, 256, 0, 1024, 768, 256},
                  '{512, 256, 256, 0, 256, 256, 0, 0, 512});

        // random matrices against the reference
        for (int t = 0; t < 10; t++) begin
            int n;
            n = (t < 6) ? 3 : 2;
            for (int x = 0; x < 9; x++)
                m[x] = int'($urandom_range(2048)) - 1024;
            if (t == 5) m[0] = 0;
            model(n, m, el, eu, me);
            load(n, m);
            run(n, -1, cyc);
            chk($sformatf("r%0d_fin", t),
                16'((n == 2) ? fin2 : fin3), 16'd1);
            chk($sformatf("r%0d_err", t),
                16'((n == 2) ? err2 : err3), 16'(me));
            if (!me)
                chk($sformatf("r%0d_lat", t), 16'(cyc), 16'(lat(n)));
            check_all(n, $sformatf("r%0d", t), el, eu);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
